// File: rtl/fifo_stream_reader.sv
// FIFO drain side: pops words into a 2-entry buffer and presents them
// as a valid/ready stream with packet framing and a delivered-beat count.
module fifo_stream_reader #(
  parameter int B       = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  input  logic [B-1:0]     fifo_r_data,
  output logic             fifo_rd,
  output logic [B-1:0]     m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } occ_t;

  occ_t          occ;
  logic [B-1:0]  buf0;
  logic [B-1:0]  buf1;
  logic [PW-1:0] pkt_idx;
  logic          cap;
  logic          hs;

  // Pop only from registered occupancy and FIFO flags, never from m_ready.
  assign fifo_rd = enable & ~fifo_empty & (occ != TWO) & ~reset;
  assign cap     = fifo_rd & fifo_valid;
  assign m_valid = (occ != EMPTY);
  assign hs      = m_valid & m_ready;
  assign m_data  = buf0;
  assign m_last  = m_valid & (pkt_idx == LAST_IDX);

  // Occupancy state: +1 on capture, -1 on handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= EMPTY;
    end else begin
      unique case (occ)
        EMPTY: if (cap) occ <= ONE;
        ONE: begin
          if (cap & ~hs) occ <= TWO;
          else if (hs & ~cap) occ <= EMPTY;
        end
        TWO: if (hs) occ <= ONE;
        default: occ <= EMPTY;
      endcase
    end
  end

  // Two-slot shift buffer; buf0 is always the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      if (hs) buf0 <= buf1;
      if (cap) begin
        if (occ == EMPTY || (occ == ONE && hs)) buf0 <= fifo_r_data;
        else buf1 <= fifo_r_data;
      end
    end
  end

  // Packet beat index, wraps after the last beat of a packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_idx <= '0;
    end else if (hs) begin
      if (pkt_idx == LAST_IDX) pkt_idx <= '0;
      else pkt_idx <= pkt_idx + PW'(1);
    end
  end

  // Delivered-beat counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) beat_cnt <= '0;
    else if (hs) beat_cnt <= beat_cnt + CNT_W'(1);
  end

endmodule
